dmem_responder: RTL and testbench

- Data-memory responder on the far end of the core's load/store port. It accepts one access per request, inserts a parameterised number of wait states, then completes with a one-cycle response.
- It holds `stall` high so the single-cycle core freezes its PC until the access completes.
- It handles byte, halfword and word sizes in the RISC-V funct3 encoding, with sign or zero extension on loads.
- It sits between the core's ALU-result/rd2 datapath and the register-file writeback mux.

---
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with LATENCY wait states and B/H/W load/store lanes
// Optional misalignment/illegal-size fault reporting: define DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        access,
  input  logic        write_enable,
  input  logic [2:0]  size,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        err
);

  localparam int AW         = $clog2(DEPTH_WORDS);
  localparam int CW         = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_INIT_I = (LATENCY > 2) ? LATENCY - 2 : 0;
  localparam logic [CW-1:0] CNT_INIT = CW'(CNT_INIT_I);
  localparam bit SINGLE = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;

  logic [AW+1:0] addr_q;
  logic [2:0]    size_q;
  logic          we_q;
  logic [31:0]   wdata_q;

  logic [AW+1:0] eff_addr;
  logic [2:0]    eff_size;
  logic          eff_we;
  logic [31:0]   eff_wdata;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          fault;
  logic          commit;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          unused_bits;
  assign unused_bits = ^address[31:AW+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && access) begin
        cnt_q <= CNT_INIT;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access) state_d = SINGLE ? DONE : BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    stall = access;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && access) begin
      addr_q  <= address[AW+1:0];
      size_q  <= size;
      we_q    <= write_enable;
      wdata_q <= write_data;
    end
  end

  // With LATENCY=1 the commit happens on the request edge, so the live inputs are used in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      eff_addr  = address[AW+1:0];
      eff_size  = size;
      eff_we    = write_enable;
      eff_wdata = write_data;
    end else begin
      eff_addr  = addr_q;
      eff_size  = size_q;
      eff_we    = we_q;
      eff_wdata = wdata_q;
    end
  end

  assign commit = (state_d == DONE) && (state_q != DONE);
  assign idx    = eff_addr[AW+1:2];
  assign lane   = eff_addr[1:0];
  assign word   = mem[idx];

  always_comb begin
    case (lane)
      2'd0:    rbyte = word[7:0];
      2'd1:    rbyte = word[15:8];
      2'd2:    rbyte = word[23:16];
      default: rbyte = word[31:24];
    endcase
    rhalf = lane[1] ? word[31:16] : word[15:0];
    case (eff_size)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_val = {24'b0, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_val = {16'b0, rhalf};
      default: load_val = word;
    endcase
  end

  always_comb begin
    case (eff_size)
      3'b000: begin
        be = 4'b0001 << lane;
        wd = {4{eff_wdata[7:0]}};
      end
      3'b001: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{eff_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = eff_wdata;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    fault = 1'b0;
    case (eff_size)
      3'b010:         fault = (lane != 2'b00);
      3'b001, 3'b101: fault = lane[0] | (eff_we & eff_size[2]);
      3'b100:         fault = eff_we;
      3'b000:         fault = 1'b0;
      default:        fault = 1'b1;
    endcase
  end
`else
  assign fault = 1'b0;
`endif

  // Storage is deliberately not reset; reset on the commit edge suppresses the store.
  always_ff @(posedge clk) begin
    if (!reset && commit && eff_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= '0;
      err       <= 1'b0;
    end else if (commit) begin
      err <= fault;
      if (!eff_we) read_data <= fault ? 32'h0 : load_val;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder against a word-array reference model
// Honours DMEM_MISALIGN_CHECK_EN the same way the design does.
module tb_dmem_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, access, write_enable;
  logic [2:0]  size;
  logic [31:0] address, write_data, read_data;
  logic        stall, err;

  logic        access1, write_enable1;
  logic [2:0]  size1;
  logic [31:0] address1, write_data1, read_data1;
  logic        stall1, err1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .access(access), .write_enable(write_enable),
    .size(size), .address(address), .write_data(write_data),
    .read_data(read_data), .stall(stall), .err(err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .access(access1), .write_enable(write_enable1),
    .size(size1), .address(address1), .write_data(write_data1),
    .read_data(read_data1), .stall(stall1), .err(err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = -100;
  bit en = 1'b0;
  logic        exp_load = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rd = '0;
  logic [31:0] hold_rd = '0;
  logic [31:0] mem_m [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic model_fault(input logic we, input logic [2:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (sz == 3'b010) return a[1:0] != 2'b00;
    if (sz == 3'b001 || sz == 3'b101) return a[0] || (we && sz == 3'b101);
    if (sz == 3'b100) return we;
    if (sz == 3'b000) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem_m[(a / 4) % DEPTH];
    b = 8'(w >> (8 * (a % 4)));
    h = 16'(w >> (16 * ((a / 2) % 2)));
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    int k;
    int sh;
    logic [31:0] m;
    k = (a / 4) % DEPTH;
    if (sz == 3'b000) begin
      sh = 8 * (a % 4);
      m  = 32'hFF << sh;
    end else if (sz == 3'b001) begin
      sh = 16 * ((a / 2) % 2);
      m  = 32'hFFFF << sh;
    end else begin
      sh = 0;
      m  = 32'hFFFF_FFFF;
    end
    mem_m[k] = (mem_m[k] & ~m) | ((d << sh) & m);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) hold_rd = '0;
  end

  // Every cycle: stall is high for exactly LAT cycles from the request, data only changes in DONE.
  always @(negedge clk) begin
    int d;
    if (en) begin
      d = cyc - req_cyc;
      if (reset) chk("stall_in_reset", {31'b0, stall}, 32'd0);
      else if (access && d < LAT) chk("stall_busy", {31'b0, stall}, 32'd1);
      else chk("stall_free", {31'b0, stall}, 32'd0);
      if (!reset && access && d == LAT) begin
        if (exp_load) hold_rd = exp_rd;
        chk("done_read_data", read_data, hold_rd);
        chk("done_err", {31'b0, err}, {31'b0, exp_err});
      end else begin
        chk("held_read_data", read_data, hold_rd);
      end
    end
  end

  task automatic do_acc(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e);
    req_cyc      = cyc;
    access       = 1'b1;
    write_enable = we;
    size         = sz;
    address      = a;
    write_data   = wd;
    exp_err      = model_fault(we, sz, a);
    exp_load     = !we;
    exp_rd       = exp_err ? 32'h0 : model_load(sz, a);
    if (we && !exp_err) model_store(sz, a, wd);
    @(posedge clk); #1;
    write_enable = 1'($urandom);
    size         = 3'($urandom);
    address      = $urandom;
    write_data   = $urandom;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    rd = read_data;
    e  = err;
    @(posedge clk); #1;
    access = 1'b0;
  endtask

  task automatic do_acc1(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd);
    access1       = 1'b1;
    write_enable1 = we;
    size1         = sz;
    address1      = a;
    write_data1   = wd;
    @(negedge clk);
    chk("lat1_stall_request", {31'b0, stall1}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat1_stall_done", {31'b0, stall1}, 32'd0);
    rd = read_data1;
    @(posedge clk); #1;
    access1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [31:0] prior;
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a;
    reset = 1'b1; access = 1'b0; write_enable = 1'b0; size = '0; address = '0; write_data = '0;
    access1 = 1'b0; write_enable1 = 1'b0; size1 = '0; address1 = '0; write_data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_read_data", read_data, 32'h0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_read_data_lat1", read_data1, 32'h0);
    en = 1'b1;

    for (int i = 0; i < DEPTH; i++) do_acc(1'b1, 3'b010, 32'(i * 4), $urandom, rd, e);

    do_acc(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e);
    do_acc(1'b0, 3'b010, 32'h10, 32'h0, rd, e);
    chk("lw_10", rd, 32'hDEADBEEF);

    do_acc(1'b1, 3'b010, 32'h20, 32'h0, rd, e);
    do_acc(1'b1, 3'b000, 32'h21, 32'h80, rd, e);
    chk("model_lw_20", model_load(3'b010, 32'h20), 32'h00008000);
    do_acc(1'b0, 3'b010, 32'h20, 32'h0, rd, e);
    chk("lw_20", rd, 32'h00008000);
    do_acc(1'b0, 3'b000, 32'h21, 32'h0, rd, e);
    chk("lb_21", rd, 32'hFFFFFF80);
    do_acc(1'b0, 3'b100, 32'h21, 32'h0, rd, e);
    chk("lbu_21", rd, 32'h00000080);

    do_acc(1'b1, 3'b001, 32'h32, 32'h0000F00D, rd, e);
    chk("model_lh_32", model_load(3'b001, 32'h32), 32'hFFFFF00D);
    do_acc(1'b0, 3'b001, 32'h32, 32'h0, rd, e);
    chk("lh_32", rd, 32'hFFFFF00D);
    do_acc(1'b0, 3'b101, 32'h32, 32'h0, rd, e);
    chk("lhu_32", rd, 32'h0000F00D);
    do_acc(1'b0, 3'b010, 32'h30, 32'h0, rd, e);
    chk("lw_30_upper", {16'h0, rd[31:16]}, 32'h0000F00D);

`ifdef DMEM_MISALIGN_CHECK_EN
    prior = model_load(3'b010, 32'h40);
    do_acc(1'b1, 3'b010, 32'h41, 32'hCAFEF00D, rd, e);
    chk("sw_41_err", {31'b0, e}, 32'd1);
    do_acc(1'b0, 3'b010, 32'h40, 32'h0, rd, e);
    chk("lw_40_unchanged", rd, prior);
    do_acc(1'b0, 3'b001, 32'h43, 32'h0, rd, e);
    chk("lh_43_err", {31'b0, e}, 32'd1);
    chk("lh_43_data", rd, 32'h0);
`endif

    prior = model_load(3'b010, 32'h50);
    req_cyc = cyc; access = 1'b1; write_enable = 1'b1; size = 3'b010;
    address = 32'h50; write_data = 32'h12345678; exp_load = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; access = 1'b0;
    chk("post_reset_data", read_data, 32'h0);
    @(negedge clk);
    chk("post_reset_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    do_acc(1'b0, 3'b010, 32'h50, 32'h0, rd, e);
    chk("lw_50_prior", rd, prior);

    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom);
      if (we) sz = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: sz = 3'b000;
          1: sz = 3'b001;
          2: sz = 3'b010;
          3: sz = 3'b100;
          default: sz = 3'b101;
        endcase
      end
      a = 32'($urandom_range(0, 4095));
      do_acc(we, sz, a, $urandom, rd, e);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    do_acc1(1'b1, 3'b010, 32'h000, 32'hA5A51234, rd);
    do_acc1(1'b0, 3'b010, 32'h400, 32'h0, rd);
    chk("lat1_alias_400", rd, 32'hA5A51234);
    do_acc1(1'b0, 3'b010, 32'h000, 32'h0, rd);
    chk("lat1_lw_000", rd, 32'hA5A51234);
    do_acc1(1'b1, 3'b000, 32'h403, 32'h0000007E, rd);
    do_acc1(1'b0, 3'b100, 32'h003, 32'h0, rd);
    chk("lat1_lbu_003", rd, 32'h0000007E);
    do_acc1(1'b0, 3'b010, 32'h000, 32'h0, rd);
    chk("lat1_lw_merged", rd, 32'h7EA51234);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
